stage_ctrl: RTL and testbench

STAGE_CTRL -- requirements
Module: stage_ctrl

---
 rtl/stage_ctrl.sv | 152 +++++++++++++++
 tb/tb_stage_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_ctrl.sv
// rtl/stage_ctrl.sv - stage sequencer for a box-pushing puzzle: load, settle, play, clear, done
module stage_ctrl #(
    parameter logic [31:0] CLEAR_CYCLES = 32'd50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        restart,
    input  logic        skip,
    input  logic        move_done,
    input  logic [63:0] boxes,
    input  logic [63:0] destination,
    output logic [1:0]  stage,
    output logic        load,
    output logic        playing,
    output logic        stage_clear,
    output logic        all_clear,
    output logic [9:0]  moves
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_PLAY,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [1:0]  r_stage;
    logic        r_load;
    logic        r_playing;
    logic        r_stage_clear;
    logic        r_all_clear;
    logic [9:0]  r_moves;
    logic [31:0] r_clear_cnt;

    logic        w_win;
    logic        w_last_stage;
    logic [9:0]  w_moves_inc;
    logic [1:0]  w_stage_next;

    // An empty destination map never counts as solved.
    assign w_win        = (destination != 64'd0) && ((boxes & destination) == destination);
    assign w_last_stage = (r_stage == 2'd3);
    assign w_moves_inc  = (r_moves == 10'd1023) ? r_moves : r_moves + 10'd1;
    assign w_stage_next = r_stage + 2'd1;

    assign stage       = r_stage;
    assign load        = r_load;
    assign playing     = r_playing;
    assign stage_clear = r_stage_clear;
    assign all_clear   = r_all_clear;
    assign moves       = r_moves;

    // Sequencer: flags are registered alongside the state so they line up with it exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_stage       <= 2'd0;
            r_load        <= 1'b0;
            r_playing     <= 1'b0;
            r_stage_clear <= 1'b0;
            r_all_clear   <= 1'b0;
            r_moves       <= 10'd0;
            r_clear_cnt   <= 32'd0;
        end else begin
            r_load        <= 1'b0;
            r_playing     <= 1'b0;
            r_stage_clear <= 1'b0;
            r_all_clear   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_LOAD;
                        r_stage <= 2'd0;
                        r_moves <= 10'd0;
                        r_load  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    // Core map only becomes valid now; the win check starts next cycle.
                    r_state   <= S_PLAY;
                    r_playing <= 1'b1;
                end
                S_PLAY: begin
                    if (restart) begin
                        r_state <= S_LOAD;
                        r_moves <= 10'd0;
                        r_load  <= 1'b1;
                    end else if (skip) begin
                        if (w_last_stage) begin
                            r_state     <= S_DONE;
                            r_all_clear <= 1'b1;
                        end else begin
                            r_state <= S_LOAD;
                            r_stage <= w_stage_next;
                            r_moves <= 10'd0;
                            r_load  <= 1'b1;
                        end
                    end else begin
                        // A move landing in the winning cycle still counts.
                        if (move_done) begin
                            r_moves <= w_moves_inc;
                        end
                        if (w_win) begin
                            r_state       <= S_CLEAR;
                            r_clear_cnt   <= CLEAR_CYCLES - 32'd1;
                            r_stage_clear <= 1'b1;
                        end else begin
                            r_playing <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    if (r_clear_cnt == 32'd0) begin
                        if (w_last_stage) begin
                            r_state     <= S_DONE;
                            r_all_clear <= 1'b1;
                        end else begin
                            r_state <= S_LOAD;
                            r_stage <= w_stage_next;
                            r_moves <= 10'd0;
                            r_load  <= 1'b1;
                        end
                    end else begin
                        r_clear_cnt   <= r_clear_cnt - 32'd1;
                        r_stage_clear <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        r_state <= S_LOAD;
                        r_stage <= 2'd0;
                        r_moves <= 10'd0;
                        r_load  <= 1'b1;
                    end else begin
                        r_all_clear <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_ctrl.sv
// tb/tb_stage_ctrl.sv - self-checking bench for stage_ctrl with a behavioural reference model
module tb_stage_ctrl;

    localparam logic [31:0] CC   = 32'd4;
    localparam logic [63:0] DEST = 64'h0010_0002_4000_0800;

    localparam logic [2:0] PH_IDLE   = 3'd5;
    localparam logic [2:0] PH_LOAD   = 3'd1;
    localparam logic [2:0] PH_SETTLE = 3'd2;
    localparam logic [2:0] PH_PLAY   = 3'd3;
    localparam logic [2:0] PH_CLEAR  = 3'd4;
    localparam logic [2:0] PH_DONE   = 3'd6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        restart = 1'b0;
    logic        skip = 1'b0;
    logic        move_done = 1'b0;
    logic [63:0] boxes = 64'd0;
    logic [63:0] destination = DEST;
    logic [1:0]  stage;
    logic        load;
    logic        playing;
    logic        stage_clear;
    logic        all_clear;
    logic [9:0]  moves;

    int n_checks = 0;
    int n_errors = 0;

    stage_ctrl #(.CLEAR_CYCLES(CC)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .restart     (restart),
        .skip        (skip),
        .move_done   (move_done),
        .boxes       (boxes),
        .destination (destination),
        .stage       (stage),
        .load        (load),
        .playing     (playing),
        .stage_clear (stage_clear),
        .all_clear   (all_clear),
        .moves       (moves)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [2:0]  phase;
        logic [1:0]  stage;
        logic [9:0]  moves;
        logic [31:0] left;
    } mstate_t;

    mstate_t m = '0;

    function automatic mstate_t m_advance(input mstate_t s);
        mstate_t n = s;
        if (s.stage == 2'd3) begin
            n.phase = PH_DONE;
        end else begin
            n.stage = s.stage + 2'd1;
            n.phase = PH_LOAD;
            n.moves = 10'd0;
        end
        return n;
    endfunction

    function automatic mstate_t m_next(input mstate_t s, input logic r, input logic st,
                                       input logic rs, input logic sk, input logic md,
                                       input logic [63:0] bx, input logic [63:0] ds);
        mstate_t n = s;
        bit solved;
        if (r) begin
            n = '0;
            n.valid = 1'b1;
            n.phase = PH_IDLE;
            return n;
        end
        solved = (ds != 64'd0) && ((bx & ds) == ds);
        case (s.phase)
            PH_IDLE, PH_DONE: begin
                if (st) begin
                    n.phase = PH_LOAD;
                    n.stage = 2'd0;
                    n.moves = 10'd0;
                end
            end
            PH_LOAD:   n.phase = PH_SETTLE;
            PH_SETTLE: n.phase = PH_PLAY;
            PH_PLAY: begin
                if (rs) begin
                    n.phase = PH_LOAD;
                    n.moves = 10'd0;
                end else if (sk) begin
                    n = m_advance(s);
                end else begin
                    if (md && s.moves < 10'd1023) n.moves = s.moves + 10'd1;
                    if (solved) begin
                        n.phase = PH_CLEAR;
                        n.left  = CC;
                    end
                end
            end
            PH_CLEAR: begin
                n.left = s.left - 32'd1;
                if (n.left == 32'd0) n = m_advance(n);
            end
            default: n.phase = PH_IDLE;
        endcase
        return n;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model advances on the same edge as the DUT.
    always @(posedge clk) begin
        m <= m_next(m, rst, start, restart, skip, move_done, boxes, destination);
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m.valid) begin
            chk("model_stage", {62'd0, stage}, {62'd0, m.stage});
            chk("model_moves", {54'd0, moves}, {54'd0, m.moves});
            chk("model_load", {63'd0, load}, {63'd0, m.phase == PH_LOAD});
            chk("model_playing", {63'd0, playing}, {63'd0, m.phase == PH_PLAY});
            chk("model_stage_clear", {63'd0, stage_clear}, {63'd0, m.phase == PH_CLEAR});
            chk("model_all_clear", {63'd0, all_clear}, {63'd0, m.phase == PH_DONE});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        rst = 1'b0;
        chk("reset_load", {63'd0, load}, 64'd0);
        chk("reset_stage", {62'd0, stage}, 64'd0);
        chk("reset_moves", {54'd0, moves}, 64'd0);
        tick(1);
        chk("no_load_after_reset", {63'd0, load}, 64'd0);

        // Start: LOAD, SETTLE, PLAY
        start = 1'b1; tick(1); start = 1'b0;
        chk("start_load", {63'd0, load}, 64'd1);
        chk("start_stage", {62'd0, stage}, 64'd0);
        tick(1);
        chk("settle_no_flags", {61'd0, load, playing, stage_clear}, 64'd0);
        tick(1);
        chk("play_after_settle", {63'd0, playing}, 64'd1);

        // Three moves, then winning move
        for (int i = 0; i < 3; i++) begin
            move_done = 1'b1; tick(1); move_done = 1'b0; tick(1);
        end
        chk("three_moves", {54'd0, moves}, 64'd3);
        boxes = DEST; move_done = 1'b1; tick(1);
        move_done = 1'b0; boxes = 64'd0;
        chk("win_moves", {54'd0, moves}, 64'd4);
        chk("win_clear", {63'd0, stage_clear}, 64'd1);
        tick(3);
        chk("clear_fourth_cycle", {63'd0, stage_clear}, 64'd1);
        tick(1);
        chk("next_stage_load", {63'd0, load}, 64'd1);
        chk("next_stage_idx", {62'd0, stage}, 64'd1);
        chk("next_stage_moves", {54'd0, moves}, 64'd0);

        // Skip stage 1 -> stage 2
        tick(2);
        skip = 1'b1; tick(1); skip = 1'b0;
        chk("skip_to_2", {62'd0, stage}, 64'd2);
        tick(2);
        move_done = 1'b1; tick(1); move_done = 1'b0;
        chk("stage2_move", {54'd0, moves}, 64'd1);
        restart = 1'b1; skip = 1'b1; move_done = 1'b1; tick(1);
        restart = 1'b0; skip = 1'b0; move_done = 1'b0;
        chk("restart_wins_load", {63'd0, load}, 64'd1);
        chk("restart_wins_stage", {62'd0, stage}, 64'd2);
        chk("restart_wins_moves", {54'd0, moves}, 64'd0);
        tick(2);
        skip = 1'b1; tick(1); skip = 1'b0;
        chk("skip_to_3", {62'd0, stage}, 64'd3);
        tick(2);

        // Stage 3 win with superset box map, ignored inputs during clear
        move_done = 1'b1; tick(1); move_done = 1'b0; tick(1);
        move_done = 1'b1; tick(1); move_done = 1'b0;
        boxes = 64'hFFFF_FFFF_FFFF_FFFF; tick(1); boxes = 64'd0;
        chk("stage3_clear", {63'd0, stage_clear}, 64'd1);
        start = 1'b1; restart = 1'b1; tick(1); start = 1'b0; restart = 1'b0;
        skip = 1'b1; move_done = 1'b1; tick(1); skip = 1'b0; move_done = 1'b0;
        tick(1);
        chk("clear_ignores_moves", {54'd0, moves}, 64'd2);
        tick(1);
        chk("done_all_clear", {63'd0, all_clear}, 64'd1);
        chk("done_stage", {62'd0, stage}, 64'd3);
        restart = 1'b1; tick(1); restart = 1'b0;
        skip = 1'b1; tick(1); skip = 1'b0;
        chk("done_holds", {63'd0, all_clear}, 64'd1);
        start = 1'b1; tick(1); start = 1'b0;
        chk("done_start_load", {63'd0, load}, 64'd1);
        chk("done_start_stage", {62'd0, stage}, 64'd0);

        // Stale win present while loading, then reset mid-clear
        boxes = DEST;
        tick(1);
        chk("stale_settle", {62'd0, playing, stage_clear}, 64'd0);
        tick(1);
        chk("stale_first_play", {63'd0, playing}, 64'd1);
        tick(1);
        chk("stale_clear", {63'd0, stage_clear}, 64'd1);
        tick(1);
        rst = 1'b1; tick(1); rst = 1'b0; boxes = 64'd0;
        chk("midclear_reset", {stage_clear, load, playing, all_clear, stage, moves}, 64'd0);
        tick(1);
        chk("idle_after_reset", {63'd0, load}, 64'd0);

        // Empty destination never wins, then move saturation
        start = 1'b1; tick(1); start = 1'b0;
        destination = 64'd0;
        tick(5);
        chk("empty_dest_no_win", {63'd0, playing}, 64'd1);
        destination = DEST;
        move_done = 1'b1; tick(1030); move_done = 1'b0;
        tick(1);
        chk("moves_saturate", {54'd0, moves}, 64'd1023);
        chk("still_playing", {63'd0, playing}, 64'd1);

        tick(1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
